// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use/branch/mult-div stalls and a mult/div busy FSM.
// Optional stall statistics counter built only when HAZARD_STATS_EN is defined.
module hazard_ctrl #(
   parameter int RA_W       = 5,
   parameter int MD_LATENCY = 8,
   parameter int CNT_W      = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [RA_W-1:0]  d_rs,
   input  logic [RA_W-1:0]  d_rt,
   input  logic             d_uses_rs,
   input  logic             d_uses_rt,
   input  logic             d_branch,
   input  logic             d_md_start,
   input  logic             d_md_read,
   input  logic             branch_taken,
   input  logic [RA_W-1:0]  e_rs,
   input  logic [RA_W-1:0]  e_rt,
   input  logic [RA_W-1:0]  e_wa,
   input  logic             e_rf_we,
   input  logic             e_mem_to_reg,
   input  logic [RA_W-1:0]  m_wa,
   input  logic             m_rf_we,
   input  logic             m_mem_to_reg,
   input  logic [RA_W-1:0]  w_wa,
   input  logic             w_rf_we,
   output logic             f_stall,
   output logic             d_stall,
   output logic             d_flush,
   output logic             e_flush,
   output logic [1:0]       fwd_a_e,
   output logic [1:0]       fwd_b_e,
   output logic             fwd_a_d,
   output logic             fwd_b_d,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_count
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_BUSY  = 1'b1;
   localparam logic [7:0] MD_LOAD = 8'(MD_LATENCY - 1);

   logic [0:0] state_reg;
   logic [7:0] cnt_reg;
   logic       lu_stall;
   logic       br_stall;
   logic       md_stall;
   logic       stall;

   // Register 0 is hard-wired, so a write to it never creates a dependency.
   function automatic logic hit(input logic [RA_W-1:0] wa, input logic [RA_W-1:0] ra);
      return (wa != '0) && (wa == ra);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] ra);
      if (m_rf_we && hit(m_wa, ra))
         return 2'b10;
      else if (w_rf_we && hit(w_wa, ra))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign fwd_a_e = fwd_sel(e_rs);
   assign fwd_b_e = fwd_sel(e_rt);
   assign fwd_a_d = m_rf_we && hit(m_wa, d_rs);
   assign fwd_b_d = m_rf_we && hit(m_wa, d_rt);

   assign lu_stall = e_mem_to_reg &&
                     ((d_uses_rs && hit(e_wa, d_rs)) || (d_uses_rt && hit(e_wa, d_rt)));
   assign br_stall = d_branch &&
                     ((e_rf_we && (hit(e_wa, d_rs) || hit(e_wa, d_rt))) ||
                      (m_mem_to_reg && (hit(m_wa, d_rs) || hit(m_wa, d_rt))));
   assign md_stall = md_busy && (d_md_read || d_md_start);
   assign stall    = lu_stall | br_stall | md_stall;

   assign f_stall = stall;
   assign d_stall = stall;
   assign e_flush = stall;
   // A stalled branch re-resolves next cycle, so the flush waits for it.
   assign d_flush = branch_taken && !stall;

   assign md_busy = (state_reg == S_BUSY);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (d_md_start && !stall) begin
                  state_reg <= S_BUSY;
                  cnt_reg   <= MD_LOAD;
               end
            end
            default: begin
               if (cnt_reg == 8'd0)
                  state_reg <= S_IDLE;
               else
                  cnt_reg <= cnt_reg - 8'd1;
            end
         endcase
      end
   end

`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] stall_count_reg;

   // Saturating: once all-ones the count stays pinned.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         stall_count_reg <= '0;
      else if (stall && (stall_count_reg != '1))
         stall_count_reg <= stall_count_reg + CNT_W'(1);
   end

   assign stall_count = stall_count_reg;
`else
   assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected outputs, a negedge monitor pops and compares.
module tb_hazard_ctrl;

`ifdef HAZARD_STATS_EN
   localparam int TB_CNT_W = 4;
`else
   localparam int TB_CNT_W = 32;
`endif

   typedef struct packed {
      logic [4:0] d_rs;
      logic [4:0] d_rt;
      logic       d_uses_rs;
      logic       d_uses_rt;
      logic       d_branch;
      logic       d_md_start;
      logic       d_md_read;
      logic       branch_taken;
      logic [4:0] e_rs;
      logic [4:0] e_rt;
      logic [4:0] e_wa;
      logic       e_rf_we;
      logic       e_mem_to_reg;
      logic [4:0] m_wa;
      logic       m_rf_we;
      logic       m_mem_to_reg;
      logic [4:0] w_wa;
      logic       w_rf_we;
   } in_t;

   typedef struct packed {
      logic       stall;
      logic       d_flush;
      logic [1:0] fa_e;
      logic [1:0] fb_e;
      logic       fa_d;
      logic       fb_d;
      logic       busy;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   in_t  cur   = '0;

   logic                f_stall, d_stall, d_flush, e_flush;
   logic [1:0]          fwd_a_e, fwd_b_e;
   logic                fwd_a_d, fwd_b_d, md_busy;
   logic [TB_CNT_W-1:0] stall_count;

   exp_t  exp_q[$];
   string nm_q[$];
   int    checks = 0;
   int    errors = 0;
   logic [TB_CNT_W-1:0] cnt_m = '0;

   always #5 clock = ~clock;

   hazard_ctrl #(.RA_W(5), .MD_LATENCY(8), .CNT_W(TB_CNT_W)) dut (
      .clock(clock), .reset(reset),
      .d_rs(cur.d_rs), .d_rt(cur.d_rt),
      .d_uses_rs(cur.d_uses_rs), .d_uses_rt(cur.d_uses_rt),
      .d_branch(cur.d_branch), .d_md_start(cur.d_md_start),
      .d_md_read(cur.d_md_read), .branch_taken(cur.branch_taken),
      .e_rs(cur.e_rs), .e_rt(cur.e_rt), .e_wa(cur.e_wa),
      .e_rf_we(cur.e_rf_we), .e_mem_to_reg(cur.e_mem_to_reg),
      .m_wa(cur.m_wa), .m_rf_we(cur.m_rf_we), .m_mem_to_reg(cur.m_mem_to_reg),
      .w_wa(cur.w_wa), .w_rf_we(cur.w_rf_we),
      .f_stall(f_stall), .d_stall(d_stall), .d_flush(d_flush), .e_flush(e_flush),
      .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
      .md_busy(md_busy), .stall_count(stall_count)
   );

   function automatic exp_t ex(input logic s, input logic df, input logic [1:0] fa,
                               input logic [1:0] fb, input logic fad, input logic fbd,
                               input logic busy);
      exp_t e;
      e = '{stall: s, d_flush: df, fa_e: fa, fb_e: fb, fa_d: fad, fb_d: fbd, busy: busy};
      return e;
   endfunction

   task automatic apply(input in_t v, input logic rst, input exp_t e, input string nm);
      @(posedge clock);
      #1;
      cur   = v;
      reset = rst;
      exp_q.push_back(e);
      nm_q.push_back(nm);
   endtask

   // Monitor: one popped expectation per falling edge, independent of the stimulus thread.
   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         exp_t                e;
         string               nm;
         logic [10:0]         act;
         logic [10:0]         req;
         logic [TB_CNT_W-1:0] cnt_req;
         e  = exp_q.pop_front();
         nm = nm_q.pop_front();
         if (reset)
            cnt_m = '0;
`ifdef HAZARD_STATS_EN
         cnt_req = cnt_m;
`else
         cnt_req = '0;
`endif
         act = {f_stall, d_stall, e_flush, d_flush, fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, md_busy};
         req = {e.stall, e.stall, e.stall, e.d_flush, e.fa_e, e.fb_e, e.fa_d, e.fb_d, e.busy};
         checks++;
         if (act !== req) begin
            errors++;
            $display("FAIL %s: outputs got %b want %b", nm, act, req);
         end else begin
            $display("ok   %s: outputs %b", nm, act);
         end
         checks++;
         if (stall_count !== cnt_req) begin
            errors++;
            $display("FAIL %s_count: stall_count got %0d want %0d", nm, stall_count, cnt_req);
         end
         if (!reset && e.stall && (cnt_m != '1))
            cnt_m = cnt_m + 1'b1;
      end
   end

   initial begin
      in_t v;
      int  waited;

      repeat (2) @(posedge clock);
      v = '0;
      apply(v, 1'b1, ex(0, 0, 2'b00, 2'b00, 0, 0, 0), "in_reset");
      apply(v, 1'b0, ex(0, 0, 2'b00, 2'b00, 0, 0, 0), "idle");

      // Forwarding priority and register-0 exclusion.
      v = '0; v.m_rf_we = 1; v.m_wa = 5; v.w_rf_we = 1; v.w_wa = 5; v.e_rs = 5; v.e_rt = 5;
      apply(v, 1'b0, ex(0, 0, 2'b10, 2'b10, 0, 0, 0), "fwd_mem_prio");
      v = '0; v.m_rf_we = 1; v.m_wa = 0; v.w_rf_we = 1; v.w_wa = 5; v.e_rs = 0; v.e_rt = 5;
      apply(v, 1'b0, ex(0, 0, 2'b00, 2'b01, 0, 0, 0), "fwd_r0");
      v = '0; v.m_rf_we = 0; v.m_wa = 5; v.w_rf_we = 1; v.w_wa = 5; v.e_rs = 5;
      apply(v, 1'b0, ex(0, 0, 2'b01, 2'b00, 0, 0, 0), "fwd_wb_only");
      v = '0; v.m_rf_we = 1; v.m_wa = 6; v.w_rf_we = 1; v.w_wa = 5; v.e_rs = 6; v.e_rt = 5;
      apply(v, 1'b0, ex(0, 0, 2'b10, 2'b01, 0, 0, 0), "fwd_split");

      // Load-use: stall one cycle, then the dependent reads the load via writeback.
      v = '0; v.e_mem_to_reg = 1; v.e_rf_we = 1; v.e_wa = 8; v.d_rs = 8; v.d_uses_rs = 1;
      apply(v, 1'b0, ex(1, 0, 2'b00, 2'b00, 0, 0, 0), "lu_stall");
      v = '0; v.m_mem_to_reg = 1; v.m_rf_we = 1; v.m_wa = 8; v.d_rs = 8; v.d_uses_rs = 1;
      apply(v, 1'b0, ex(0, 0, 2'b00, 2'b00, 1, 0, 0), "lu_bubble");
      v = '0; v.w_rf_we = 1; v.w_wa = 8; v.e_rs = 8;
      apply(v, 1'b0, ex(0, 0, 2'b01, 2'b00, 0, 0, 0), "lu_wb_fwd");
      v = '0; v.e_mem_to_reg = 1; v.e_rf_we = 1; v.e_wa = 8; v.d_rs = 8; v.d_uses_rs = 0;
      apply(v, 1'b0, ex(0, 0, 2'b00, 2'b00, 0, 0, 0), "lu_unused_rs");
      v = '0; v.e_mem_to_reg = 1; v.e_rf_we = 1; v.e_wa = 9; v.d_rt = 9; v.d_uses_rt = 1;
      apply(v, 1'b0, ex(1, 0, 2'b00, 2'b00, 0, 0, 0), "lu_rt");
      v = '0; v.e_mem_to_reg = 1; v.e_wa = 0; v.d_rs = 0; v.d_uses_rs = 1;
      apply(v, 1'b0, ex(0, 0, 2'b00, 2'b00, 0, 0, 0), "lu_r0");

      // Branch compare hazards and flush suppression.
      v = '0; v.d_branch = 1; v.d_rt = 3; v.d_uses_rt = 1; v.e_rf_we = 1; v.e_wa = 3; v.branch_taken = 1;
      apply(v, 1'b0, ex(1, 0, 2'b00, 2'b00, 0, 0, 0), "br_stall_ex");
      v = '0; v.d_branch = 1; v.d_rt = 3; v.d_uses_rt = 1; v.m_rf_we = 1; v.m_wa = 3; v.branch_taken = 1;
      apply(v, 1'b0, ex(0, 1, 2'b00, 2'b00, 0, 1, 0), "br_fwd_flush");
      v = '0; v.d_branch = 1; v.d_rs = 7; v.m_rf_we = 1; v.m_mem_to_reg = 1; v.m_wa = 7;
      apply(v, 1'b0, ex(1, 0, 2'b00, 2'b00, 1, 0, 0), "br_stall_load");
      v = '0; v.d_branch = 1; v.e_rf_we = 1; v.e_wa = 0; v.d_rs = 0; v.branch_taken = 1;
      apply(v, 1'b0, ex(0, 1, 2'b00, 2'b00, 0, 0, 0), "br_r0");
      v = '0; v.d_rs = 3; v.e_rf_we = 1; v.e_wa = 3;
      apply(v, 1'b0, ex(0, 0, 2'b00, 2'b00, 0, 0, 0), "nonbranch_dep");

      // A start blocked by another stall is not accepted.
      v = '0; v.d_md_start = 1; v.e_mem_to_reg = 1; v.e_wa = 4; v.d_rs = 4; v.d_uses_rs = 1;
      apply(v, 1'b0, ex(1, 0, 2'b00, 2'b00, 0, 0, 0), "md_start_blocked");
      v = '0;
      apply(v, 1'b0, ex(0, 0, 2'b00, 2'b00, 0, 0, 0), "md_not_started");

      // Mult/div busy for 8 cycles; the read proceeds on the 9th.
      v = '0; v.d_md_start = 1;
      apply(v, 1'b0, ex(0, 0, 2'b00, 2'b00, 0, 0, 0), "md_start");
      v = '0; v.d_md_read = 1;
      for (int i = 0; i < 8; i++)
         apply(v, 1'b0, ex(1, 0, 2'b00, 2'b00, 0, 0, 1), "md_read_wait");
      apply(v, 1'b0, ex(0, 0, 2'b00, 2'b00, 0, 0, 0), "md_read_go");

      // Start during busy stalls and is taken on the first idle cycle; reset aborts mid-busy.
      v = '0; v.d_md_start = 1;
      apply(v, 1'b0, ex(0, 0, 2'b00, 2'b00, 0, 0, 0), "md_start2");
      for (int i = 0; i < 8; i++)
         apply(v, 1'b0, ex(1, 0, 2'b00, 2'b00, 0, 0, 1), "md_start_wait");
      apply(v, 1'b0, ex(0, 0, 2'b00, 2'b00, 0, 0, 0), "md_start_taken");
      v = '0;
      apply(v, 1'b0, ex(0, 0, 2'b00, 2'b00, 0, 0, 1), "md_busy_c1");
      v = '0; v.d_md_read = 1;
      apply(v, 1'b0, ex(1, 0, 2'b00, 2'b00, 0, 0, 1), "md_busy_c2");
      apply(v, 1'b0, ex(1, 0, 2'b00, 2'b00, 0, 0, 1), "md_busy_c3");
      apply(v, 1'b1, ex(0, 0, 2'b00, 2'b00, 0, 0, 0), "md_reset_c4");
      apply(v, 1'b0, ex(0, 0, 2'b00, 2'b00, 0, 0, 0), "md_after_reset");

      // Twenty consecutive stall cycles exercise counter saturation when statistics are built.
      v = '0; v.e_mem_to_reg = 1; v.e_wa = 10; v.d_rs = 10; v.d_uses_rs = 1;
      for (int i = 0; i < 20; i++)
         apply(v, 1'b0, ex(1, 0, 2'b00, 2'b00, 0, 0, 0), "stall_run");
      v = '0;
      apply(v, 1'b0, ex(0, 0, 2'b00, 2'b00, 0, 0, 0), "stall_hold");
      apply(v, 1'b0, ex(0, 0, 2'b00, 2'b00, 0, 0, 0), "final_idle");

      waited = 0;
      while (exp_q.size() > 0 && waited < 20) begin
         @(posedge clock);
         waited++;
      end
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: pending %0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
